// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the register-file master and the
// blocks around it (regfile model, benches).
//   DATA_W   : default register data width
//   NREG     : default register count
//   cmd_op_e : command opcode encoding carried on cmd_op
//   state_e  : master FSM states
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/regfile_master.sv
// regfile_master -- command-driven master for an external register file.
// Accepts WRITE / READ / DUMP commands, drives the regfile write/read ports
// and returns read values over a valid/ready response channel. DUMP walks
// every register 0..NREG-1, one response per register.
//
// Ports
//   clk, reset_n          : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_ready only in IDLE
//   cmd_op/cmd_reg/cmd_data : opcode, register index, write data
//   rsp_valid/rsp_ready   : response handshake; response held until consumed
//   rsp_reg/rsp_data      : index and value of the register read
//   rf_data_in/rf_writenum/rf_write : regfile write port (write for one cycle)
//   rf_readnum/rf_data_out : regfile read index and combinational read data
//   busy                  : high whenever the FSM is not IDLE
module regfile_master #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREG   = regfile_pkg::NREG,
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_reg,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDX_W-1:0]  rsp_reg,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [IDX_W-1:0]  rf_writenum,
  output logic              rf_write,
  output logic [IDX_W-1:0]  rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              busy
);

  import regfile_pkg::*;

  state_e             state_reg, state_next;
  cmd_op_e            op_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   rf_readnum_reg;
  logic [IDX_W-1:0]   rf_writenum_reg;
  logic [DATA_W-1:0]  rf_data_in_reg;
  logic [IDX_W-1:0]   rsp_reg_reg;
  logic [DATA_W-1:0]  rsp_data_reg;

  logic    accept;
  logic    rsp_fire;
  logic    last_idx;
  cmd_op_e cmd_op_in;

  assign cmd_op_in = cmd_op_e'(cmd_op);
  // Gated by reset_n so the port is low for the whole time reset is held.
  assign cmd_ready = (state_reg == ST_IDLE) && reset_n;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_fire  = (state_reg == ST_RESP) && rsp_ready;
  assign last_idx  = (idx_reg == IDX_W'(NREG - 1));

  // Decoded straight from the state register, so an asynchronous reset
  // drops rf_write / rsp_valid / busy immediately.
  assign rf_write    = (state_reg == ST_WR);
  assign rsp_valid   = (state_reg == ST_RESP);
  assign busy        = (state_reg != ST_IDLE);
  assign rf_readnum  = rf_readnum_reg;
  assign rf_writenum = rf_writenum_reg;
  assign rf_data_in  = rf_data_in_reg;
  assign rsp_reg     = rsp_reg_reg;
  assign rsp_data    = rsp_data_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_in)
            OP_WRITE: state_next = ST_WR;
            OP_READ,
            OP_DUMP:  state_next = ST_RD;
            default:  state_next = ST_IDLE;  // reserved: dropped silently
          endcase
        end
      end
      ST_WR:   state_next = ST_IDLE;
      ST_RD:   state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_fire) begin
          // A DUMP stops after the last register rather than wrapping.
          if ((op_reg == OP_DUMP) && !last_idx) state_next = ST_RD;
          else                                   state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      op_reg          <= OP_WRITE;
      idx_reg         <= '0;
      rf_readnum_reg  <= '0;
      rf_writenum_reg <= '0;
      rf_data_in_reg  <= '0;
      rsp_reg_reg     <= '0;
      rsp_data_reg    <= '0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        op_reg          <= cmd_op_in;
        rf_writenum_reg <= cmd_reg;
        rf_data_in_reg  <= cmd_data;
        // The read index is set up on entry to RD and then left alone, so
        // rf_readnum keeps its last value outside RD.
        if (cmd_op_in == OP_READ) begin
          idx_reg        <= cmd_reg;
          rf_readnum_reg <= cmd_reg;
        end else if (cmd_op_in == OP_DUMP) begin
          idx_reg        <= '0;
          rf_readnum_reg <= '0;
        end
      end

      if (state_reg == ST_RD) begin
        rsp_data_reg <= rf_data_out;
        rsp_reg_reg  <= idx_reg;
      end

      if (rsp_fire && (op_reg == OP_DUMP) && !last_idx) begin
        idx_reg        <= idx_reg + 1'b1;
        rf_readnum_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_master.sv
module tb_regfile_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_reg;
  logic [15:0] rsp_data;
  logic [15:0] rf_data_in;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;
  logic        busy;

  regfile_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_reg    (cmd_reg),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_reg    (rsp_reg),
    .rsp_data   (rsp_data),
    .rf_data_in (rf_data_in),
    .rf_writenum(rf_writenum),
    .rf_write   (rf_write),
    .rf_readnum (rf_readnum),
    .rf_data_out(rf_data_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Simple regfile the master drives: registered write, combinational read.
  logic [15:0] regs [0:7];
  always @(posedge clk) if (rf_write === 1'b1) regs[rf_writenum] <= rf_data_in;
  assign rf_data_out = regs[rf_readnum];

  // Reference model: what each register should hold.
  logic [15:0] model [0:7];
  int init_vals [8] = '{3, 15, 2000, 128, 50, 25, 250, 2200};

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_count = 0;
  int acc_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_write === 1'b1) wr_count <= wr_count + 1;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input logic [1:0] op, input int r, input logic [15:0] d, output bit ok);
    cmd_op = op; cmd_reg = 3'(r); cmd_data = d; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (cmd_ready === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL cmd_accept_timeout: cmd_ready never rose, required 1");
    end else begin
      acc_cyc = cyc;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (rsp_valid === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL rsp_timeout: rsp_valid never rose, required 1");
    end
  endtask

  task automatic do_write(input int r, input logic [15:0] d);
    bit ok;
    send_cmd(2'b00, r, d, ok);
    if (!ok) return;
    n_vec++; if (rf_write !== 1'b1) begin n_err++; $display("FAIL wr_enable: got %b want 1", rf_write); end
    n_vec++; if (rf_writenum !== 3'(r)) begin n_err++; $display("FAIL wr_num: got %0d want %0d", rf_writenum, r); end
    n_vec++; if (rf_data_in !== d) begin n_err++; $display("FAIL wr_data: got %0d want %0d", rf_data_in, d); end
    @(posedge clk); #1;
    model[r] = d;
    n_vec++; if (regs[r] !== model[r]) begin n_err++; $display("FAIL wr_reg%0d: got %0d want %0d", r, regs[r], model[r]); end
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL wr_one_cycle: got %b want 0", rf_write); end
    $display("WRITE R%0d = %0d", r, d);
  endtask

  task automatic do_read(input int r, input int stall);
    bit ok;
    logic [15:0] held;
    rsp_ready = (stall == 0);
    send_cmd(2'b01, r, 16'h0, ok);
    if (!ok) return;
    n_vec++; if (rf_readnum !== 3'(r)) begin n_err++; $display("FAIL rd_num: got %0d want %0d", rf_readnum, r); end
    wait_rsp(ok);
    if (!ok) return;
    n_vec++; if (cyc - acc_cyc !== 2) begin n_err++; $display("FAIL rd_latency: got %0d want 2", cyc - acc_cyc); end
    n_vec++; if (rsp_data !== model[r]) begin n_err++; $display("FAIL rd_data: got %0d want %0d", rsp_data, model[r]); end
    n_vec++; if (rsp_reg !== 3'(r)) begin n_err++; $display("FAIL rd_reg: got %0d want %0d", rsp_reg, r); end
    held = model[r];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== held) begin
        n_err++; $display("FAIL rd_stall_hold: got valid=%b data=%0d want 1/%0d", rsp_valid, rsp_data, held);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_done: got busy=%b valid=%b want 0/0", busy, rsp_valid); end
    rsp_ready = 1'b0;
    $display("READ R%0d -> %0d (stall %0d)", r, rsp_data, stall);
  endtask

  // abort_idx < 0: run to completion; otherwise reset while that register's
  // response is being offered.
  task automatic do_dump(input int stall_idx, input int stall_n, input int abort_idx);
    bit ok;
    rsp_ready = 1'b0;
    send_cmd(2'b10, 0, 16'h0, ok);
    if (!ok) return;
    for (int i = 0; i < 8; i++) begin
      wait_rsp(ok);
      if (!ok) return;
      n_vec++; if (rsp_reg !== 3'(i)) begin n_err++; $display("FAIL dump_reg: got %0d want %0d", rsp_reg, i); end
      n_vec++; if (rsp_data !== model[i]) begin n_err++; $display("FAIL dump_data%0d: got %0d want %0d", i, rsp_data, model[i]); end
      n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL dump_cmd_ready: got %b want 0", cmd_ready); end
      if (i == abort_idx) begin
        #1 reset_n = 1'b0;
        #1;
        n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL dump_abort: got valid=%b busy=%b want 0/0", rsp_valid, busy); end
        n_vec++; if (rsp_data !== 16'h0 || rf_readnum !== 3'h0) begin n_err++; $display("FAIL dump_abort_clear: got data=%0d readnum=%0d want 0/0", rsp_data, rf_readnum); end
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        $display("DUMP aborted by reset at R%0d", i);
        return;
      end
      for (int s = 0; s < ((i == stall_idx) ? stall_n : 0); s++) begin
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_data !== model[i] || rsp_reg !== 3'(i)) begin
          n_err++; $display("FAIL dump_stall_hold: got valid=%b reg=%0d data=%0d want 1/%0d/%0d", rsp_valid, rsp_reg, rsp_data, i, model[i]);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      $display("DUMP R%0d -> %0d", i, model[i]);
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL dump_end_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_reg = 3'h0; cmd_data = 16'h0; rsp_ready = 1'b0;
    #2;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_vec++; if ({busy, rsp_valid, rf_write} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {busy, rsp_valid, rf_write}); end
    n_vec++; if ({rsp_data, rsp_reg} !== 19'h0) begin n_err++; $display("FAIL rst_rsp: got %h want 0", {rsp_data, rsp_reg}); end
    n_vec++; if ({rf_data_in, rf_writenum, rf_readnum} !== 22'h0) begin n_err++; $display("FAIL rst_rf: got %h want 0", {rf_data_in, rf_writenum, rf_readnum}); end
    @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    $display("RESET released");
  endtask

  task automatic test_write_all();
    int w0 = wr_count;
    for (int i = 0; i < 8; i++) do_write(i, 16'(init_vals[i]));
    n_vec++; if (wr_count - w0 !== 8) begin n_err++; $display("FAIL wr_cycles: got %0d want 8", wr_count - w0); end
  endtask

  task automatic test_reserved();
    bit ok;
    int w0 = wr_count;
    send_cmd(2'b11, 5, 16'd20, ok);
    for (int s = 0; s < 3; s++) begin
      n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rsvd_quiet: got valid=%b busy=%b want 0/0", rsp_valid, busy); end
      @(posedge clk); #1;
    end
    n_vec++; if (wr_count !== w0) begin n_err++; $display("FAIL rsvd_no_write: got %0d writes want 0", wr_count - w0); end
    n_vec++; if (regs[5] !== model[5]) begin n_err++; $display("FAIL rsvd_r5: got %0d want %0d", regs[5], model[5]); end
    $display("RESERVED op ignored, R5 = %0d", regs[5]);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    send_cmd(2'b00, 5, 16'd99, ok);
    n_vec++; if (rf_write !== 1'b1) begin n_err++; $display("FAIL rstwr_in_wr: got %b want 1", rf_write); end
    #1 reset_n = 1'b0;
    #1;
    n_vec++; if (rf_write !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstwr_drop: got write=%b busy=%b want 0/0", rf_write, busy); end
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (regs[5] !== model[5]) begin n_err++; $display("FAIL rstwr_r5: got %0d want %0d", regs[5], model[5]); end
    $display("RESET during WRITE R5=99, R5 = %0d", regs[5]);
  endtask

  // A command held while the master is busy must wait, then be taken.
  task automatic test_held_cmd();
    bit ok;
    int w0;
    logic [15:0] d = 16'($urandom);
    rsp_ready = 1'b0;
    send_cmd(2'b01, 0, 16'h0, ok);
    cmd_op = 2'b00; cmd_reg = 3'd6; cmd_data = d; cmd_valid = 1'b1;
    w0 = wr_count;
    wait_rsp(ok);
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL held_not_taken: got %b want 0", cmd_ready); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_vec++; if (wr_count !== w0) begin n_err++; $display("FAIL held_early_write: got %0d want 0", wr_count - w0); end
    do_write(6, d);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      int r = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) do_write(r, 16'($urandom));
      else do_read(r, $urandom_range(0, 3));
    end
    do_dump($urandom_range(0, 7), $urandom_range(1, 3), -1);
  endtask

  initial begin
    test_reset();
    test_write_all();
    rsp_ready = 1'b1;
    do_read(2, 0);
    do_dump(3, 3, -1);
    do_write(1, 16'd18);
    do_read(1, 0);
    test_reserved();
    test_reset_mid_write();
    do_dump(-1, 0, 4);
    do_dump(-1, 0, -1);
    test_held_cmd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
